// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, counter-width
// helper and the value the arbiter parks the bus at while idle.
// Latency: n/a (package). Backpressure: n/a.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } arb_state_t;

  // clog2 that never returns 0, so a counter or index for a size of 1 still
  // gets a legal one-bit vector.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit value replicated across dbus while the arbiter parks the bus.
  localparam logic PARK_BIT = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from i_last+1 (mod N). Latency: 0 cycles. Backpressure: none.
// Ports: i_req (requests), i_last (previous winner), o_any (some request set),
//        o_idx (winning index, 0 when o_any=0).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;

  // Offsets 1..N: the previous winner (offset N) is checked last, which is
  // what gives a preempted requester the lowest priority.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = IW'((int'(i_last) + i) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared 3-state bus with max hold time and dead
// turnaround cycles. Latency: req in IDLE -> en on the next edge (1 cycle).
// Backpressure: a grant is held while req[owner] stays high, up to MAX_HOLD.
// Ports: clk, rst (sync, active-high), req[N] level requests, en[N] registered
//        one-hot-or-zero drive enables, owner (valid while busy), busy, dbus.
// Optional macro BUS_PARK_EN: arbiter drives dbus low while IDLE; otherwise
// dbus is never driven by the arbiter.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  N        = 4,
  parameter int  WIDTH    = 4,
  parameter int  MAX_HOLD = 8,
  parameter int  TURN     = 1,
  localparam int IW       = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     en,
  output logic [IW-1:0]    owner,
  output logic             busy,
  inout  wire  [WIDTH-1:0] dbus
);

  localparam int HW = clog2_min1(MAX_HOLD);
  localparam int TW = clog2_min1(TURN);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [N-1:0]  r_en;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_turn;

  logic          w_arb;      // arbitration happens at the coming edge
  logic          w_release;  // current grant ends at the coming edge
  logic          w_any;
  logic [IW-1:0] w_idx;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE:  w_arb = 1'b1;
      // Expiry preempts even while the owner still requests.
      S_GRANT: w_release = !req[r_owner] || (r_hold == HOLD_LAST);
      // Only the last dead cycle arbitrates, so en stays low exactly TURN cycles.
      S_TURN:  w_arb = (r_turn == TURN_LAST);
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_arb) begin
      w_state_nxt = w_any ? S_GRANT : S_IDLE;
    end else if (w_release) begin
      w_state_nxt = S_TURN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_en    <= '0;
      r_owner <= '0;
      r_last  <= IW'(N - 1);
      r_hold  <= '0;
      r_turn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb && w_any) begin
        r_en    <= N'(1) << w_idx;
        r_owner <= w_idx;
        r_last  <= w_idx;
        r_hold  <= '0;
      end else if (r_state == S_GRANT) begin
        if (w_release) begin
          r_en   <= '0;
          r_turn <= '0;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end else if (r_state == S_TURN) begin
        r_turn <= r_turn + 1'b1;
      end
    end
  end

  assign en    = r_en;
  assign owner = r_owner;
  assign busy  = |r_en;

`ifdef BUS_PARK_EN
  // Park driver lets go on the same edge en rises; the new owner drives a
  // cycle later, so the two never overlap.
  assign dbus = (r_state == S_IDLE) ? {WIDTH{PARK_BIT}} : {WIDTH{1'bz}};
`else
  assign dbus = {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req2;
  logic [3:0] en, en2;
  logic [1:0] owner, owner2;
  logic       busy, busy2;
  wire  [3:0] dbus, dbus2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N(4), .WIDTH(4), .MAX_HOLD(8), .TURN(1)) dut (
    .clk(clk), .rst(rst), .req(req), .en(en), .owner(owner), .busy(busy), .dbus(dbus)
  );

  bus_arbiter #(.N(4), .WIDTH(4), .MAX_HOLD(3), .TURN(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .en(en2), .owner(owner2), .busy(busy2), .dbus(dbus2)
  );

  // Advance one cycle; observe and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    req2 = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    req2 = 4'b0000;
    tick();
    checks++;
    if (en !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: en=%b busy=%b owner=%0d, want en=0000 busy=0 owner=0", en, busy, owner);
    end
    checks++;
    if (en2 !== 4'b0000 || busy2 !== 1'b0 || owner2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state2: en=%b busy=%b owner=%0d, want en=0000 busy=0 owner=0", en2, busy2, owner2);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (en !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_req cyc%0d: en=%b busy=%b, want 0000/0", c, en, busy);
      end
`ifdef BUS_PARK_EN
      checks++;
      if (dbus !== 4'b0000) begin
        failures++;
        $display("FAIL idle_park cyc%0d: dbus=%b, want 0000", c, dbus);
      end
`endif
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;                     // cycle 0
    tick();                            // cycle 1
    checks++;
    if (en !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: en=%b owner=%0d busy=%b, want 0100/2/1", en, owner, busy);
    end
    tick();
    tick();                            // cycle 3
    checks++;
    if (en !== 4'b0100) begin
      failures++;
      $display("FAIL single_hold: en=%b, want 0100", en);
    end
    req = 4'b0000;
    tick();                            // cycle 4: TURN
    checks++;
    if (en !== 4'b0000 || busy !== 1'b0 || owner !== 2'd2) begin
      failures++;
      $display("FAIL single_release: en=%b busy=%b owner=%0d, want 0000/0/2", en, busy, owner);
    end
    tick();                            // cycle 5: back in IDLE
    checks++;
    if (en !== 4'b0000) begin
      failures++;
      $display("FAIL single_idle: en=%b, want 0000", en);
    end
`ifdef BUS_PARK_EN
    checks++;
    if (dbus !== 4'b0000) begin
      failures++;
      $display("FAIL single_park: dbus=%b, want 0000", dbus);
    end
`endif
    // last=2: rotation from 3 wraps to 0
    req = 4'b0001;
    tick();
    checks++;
    if (en !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL single_next: en=%b owner=%0d, want 0001/0", en, owner);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_en;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_en = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        checks++;
        if (en !== exp_en || owner !== 2'(g % 4)) begin
          failures++;
          $display("FAIL rr_grant g%0d c%0d: en=%b owner=%0d, want %b/%0d", g, c, en, owner, exp_en, g % 4);
        end
      end
      tick();
      checks++;
      if (en !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_turn g%0d: en=%b busy=%b, want 0000/0", g, en, busy);
      end
    end
  endtask

  task automatic test_hold_turn();
    logic exp_bit;
    do_reset();
    req2 = 4'b0001;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_bit = ((k - 1) % 5) < 3;
      checks++;
      if (en2 !== {3'b000, exp_bit}) begin
        failures++;
        $display("FAIL hold_turn cyc%0d: en=%b, want %b", k, en2, {3'b000, exp_bit});
      end
    end
  endtask

  task automatic test_non_owner();
    do_reset();
    req = 4'b0010;
    tick();                            // cycle 1: owner 1
    req = 4'b1110;
    tick();
    tick();                            // cycle 3
    checks++;
    if (en !== 4'b0010 || owner !== 2'd1) begin
      failures++;
      $display("FAIL non_owner_hold: en=%b owner=%0d, want 0010/1", en, owner);
    end
    req = 4'b1100;
    tick();                            // cycle 4: TURN
    checks++;
    if (en !== 4'b0000) begin
      failures++;
      $display("FAIL non_owner_release: en=%b, want 0000", en);
    end
    tick();                            // cycle 5: rotation from 2
    checks++;
    if (en !== 4'b0100 || owner !== 2'd2) begin
      failures++;
      $display("FAIL non_owner_next: en=%b owner=%0d, want 0100/2", en, owner);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    tick();
    checks++;
    if (en !== 4'b1000 || owner !== 2'd3) begin
      failures++;
      $display("FAIL mid_rst_setup: en=%b owner=%0d, want 1000/3", en, owner);
    end
    tick();
    rst = 1'b1;
    req = 4'b1001;
    tick();
    checks++;
    if (en !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst_drop: en=%b busy=%b owner=%0d, want 0000/0/0", en, busy, owner);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (en !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst_regrant: en=%b owner=%0d, want 0001/0", en, owner);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_en;
    int zero_run;
    int hold_run;
    int wait_cnt [4];
    do_reset();
    prev_en  = 4'b0000;
    zero_run = 0;
    hold_run = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      checks++;
      if ($countones(en) > 1) begin
        failures++;
        $display("FAIL rand_onehot cyc%0d: en=%b, want popcount<=1", cyc, en);
      end
      if (en != 4'b0000) begin
        if (en != prev_en) begin
          // every new grant needs at least TURN (1) idle cycles before it
          checks++;
          if (prev_en != 4'b0000 || zero_run < 1) begin
            failures++;
            $display("FAIL rand_gap cyc%0d: en %b->%b zero_run=%0d, want >=1", cyc, prev_en, en, zero_run);
          end
          hold_run = 1;
        end else begin
          hold_run++;
        end
        checks++;
        if (hold_run > 8 || en !== (4'b0001 << owner)) begin
          failures++;
          $display("FAIL rand_hold cyc%0d: run=%0d en=%b owner=%0d, want run<=8 and en=onehot(owner)", cyc, hold_run, en, owner);
        end
        zero_run = 0;
      end else begin
        zero_run = (cyc == 0) ? 1 : zero_run + 1;
      end
      for (int i = 0; i < 4; i++) begin
        wait_cnt[i] = (req[i] && !en[i]) ? wait_cnt[i] + 1 : 0;
        checks++;
        if (wait_cnt[i] > 27) begin
          failures++;
          $display("FAIL rand_starve cyc%0d user%0d: waited=%0d, want <=27", cyc, i, wait_cnt[i]);
        end
      end
      prev_en = en;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    req2 = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_turn();
    test_non_owner();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central controller for the shared 3-state data bus. It is the counterpart to the per-user bus drivers.
- Accepts level requests from N bus users and issues the one-hot-or-zero drive enables (`en`) that those users consume.
- Enforces round-robin fairness, a maximum hold time per grant, and dead turnaround cycles between owners so that two drivers never overlap.

Parameters:
- N, 4, number of bus users (>=2).
- WIDTH, 4, data bus bit width.
- MAX_HOLD, 8, maximum consecutive cycles one user may hold `en` (>=1).
- TURN, 1, dead cycles with all enables low between grants (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N  per-user level request; held high while the user wants the bus.
- en  output  N  per-user drive enable; registered, one-hot or all-zero.
- owner  output  clog2(N)  index of the current grantee; valid while busy=1.
- busy  output  1  high while any en bit is high.
- dbus  inout  WIDTH  shared bus; driven only by the BUS_PARK_EN feature, otherwise always z.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on posedge clk.
  - Reset is synchronous and active-high.
  - Reset values: en=0, busy=0, owner=0, state=IDLE, hold counter=0, turn counter=0.
  - Round-robin pointer last=N-1 after reset, so user 0 has first priority.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0, pick the first set req bit searching upward from last+1 (mod N).
  - Next cycle: state=GRANT, en=onehot(pick), owner=pick, last=pick, hold=0, busy=1.
  - Grant latency: req sampled high in IDLE gives en high on the following edge (1 cycle).
  - If req=0, stay in IDLE.
- GRANT:
  - hold increments each cycle.
  - Release when req[owner]=0, or when hold==MAX_HOLD-1. Expiry preempts even if req is still high.
  - On release, next cycle: en=0, busy=0, state=TURN, turn=0.
  - owner keeps its last value while busy=0.
- TURN:
  - All enables stay low for exactly TURN cycles.
  - On the final TURN cycle, arbitrate as in IDLE using current req. The next cycle is GRANT with a new en, or IDLE if req=0.
  - The minimum gap between two grants is therefore TURN cycles with en=0.
- Fairness:
  - A preempted user that keeps req high gets lowest priority at the next arbitration, because last=owner.
  - A single requester with continuous req cycles GRANT(MAX_HOLD) -> TURN(TURN) -> GRANT.
- Edge cases:
  - req bits of non-owners changing during GRANT have no effect until the next arbitration.
  - Multiple simultaneous requests in IDLE are resolved purely by the rotation order.
  - If MAX_HOLD=1, every grant lasts exactly 1 cycle.
  - rst during GRANT or TURN: en drops to 0 on that same edge, with no turnaround guarantee across reset.
- Invariant: popcount(en)<=1 in every cycle.

Optional Feature:
- Macro: BUS_PARK_EN.
- Defined:
  - The arbiter drives dbus to {WIDTH{1'b0}} whenever state==IDLE (held low while idle) so the bus never floats.
  - The park driver releases on the same edge that en is asserted. Users drive a cycle later, so there is no overlap.
  - The park driver is not active in TURN or GRANT.
- Not defined: dbus is permanently z and never driven by the arbiter, so the bus floats when idle.

Decomposition:
- Package bus_arb_pkg:
  - state enum {IDLE, GRANT, TURN}.
  - Width constants or helper function for clog2(N), clog2(MAX_HOLD) and clog2(TURN).
  - Park value constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N], last.
  - Outputs: any, idx.
  - Instantiated once.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> en=0, busy=0 throughout. With BUS_PARK_EN, dbus=0; without it, dbus=z.
- req=4'b0100 at cycle 0 -> en=4'b0100 and owner=2 at cycle 1. Drop req at cycle 3 -> en=0 at cycle 4, TURN lasts 1 cycle, state back to IDLE.
- req=4'b1111 held -> grant order 0,1,2,3,0, each lasting 8 cycles. Exactly 1 all-zero cycle between consecutive grants.
- req=4'b0001 held with MAX_HOLD=3, TURN=2 -> repeating en pattern 1,1,1,0,0.
- rst asserted mid-GRANT with owner=3 -> next edge en=0. After release, with req=4'b1001, user 0 is granted first.
- Random req for 10k cycles -> checker confirms popcount(en)<=1, at least TURN zero-cycles at every ownership change, no grant longer than MAX_HOLD, and no starvation beyond (N-1)*(MAX_HOLD+TURN) cycles.
